alu_seq: RTL and testbench

ALU_SEQ -- requirements
Module: alu_seq

---
 rtl/alu_seq_if.sv | 35 +++
 rtl/alu_seq.sv | 245 ++++++++++++++++++++++++
 tb/tb_alu_seq.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/alu_seq_if.sv
// alu_seq_if: request/response bundle for the sequential ALU.
//   Request  (master -> slave): in_valid, op[7:0], a, b
//   Response (slave -> master): in_ready, out_valid, out, out_hi,
//                               zflag, nflag, cflag, vflag, sflag, hflag, err
interface alu_seq_if #(
  parameter int unsigned WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [7:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic [WIDTH-1:0] out;
  logic [WIDTH-1:0] out_hi;
  logic             zflag;
  logic             nflag;
  logic             cflag;
  logic             vflag;
  logic             sflag;
  logic             hflag;
  logic             err;

  modport master (
    output in_valid, op, a, b,
    input  in_ready, out_valid, out, out_hi,
    input  zflag, nflag, cflag, vflag, sflag, hflag, err
  );

  modport slave (
    input  in_valid, op, a, b,
    output in_ready, out_valid, out, out_hi,
    output zflag, nflag, cflag, vflag, sflag, hflag, err
  );
endinterface

// File: rtl/alu_seq.sv
// alu_seq: sequential ALU. Single-cycle ops produce a registered result one cycle after
// acceptance; MUL runs an unsigned shift-add multiplier, one bit per cycle for WIDTH cycles.
// Ports:
//   clk  - clock, all state on the rising edge
//   rst  - synchronous active-high reset
//   bus  - alu_seq_if.slave: in_valid/in_ready request handshake with op/a/b, registered
//          out/out_hi/flags/err qualified by a one-cycle out_valid pulse
module alu_seq #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned SHW   = $clog2(WIDTH)
) (
  input  logic       clk,
  input  logic       rst,
  alu_seq_if.slave   bus
);

  localparam logic [7:0] OpLd  = 8'h01;
  localparam logic [7:0] OpAdd = 8'h03;
  localparam logic [7:0] OpSub = 8'h04;
  localparam logic [7:0] OpAnd = 8'h05;
  localparam logic [7:0] OpOr  = 8'h06;
  localparam logic [7:0] OpXor = 8'h07;
  localparam logic [7:0] OpNot = 8'h08;
  localparam logic [7:0] OpSl  = 8'h09;
  localparam logic [7:0] OpSr  = 8'h0A;
  localparam logic [7:0] OpAdc = 8'h0B;
  localparam logic [7:0] OpSbc = 8'h0C;
  localparam logic [7:0] OpAsr = 8'h0D;
  localparam logic [7:0] OpRol = 8'h0E;
  localparam logic [7:0] OpMul = 8'h0F;
  localparam logic [7:0] OpCmp = 8'h10;

  localparam logic [WIDTH-1:0] WidthVal = WIDTH'(WIDTH);
  localparam logic [SHW:0]     LastIter = (SHW + 1)'(WIDTH - 1);

  typedef enum logic [0:0] {StIdle, StMul} state_e;

  state_e             r_state;
  logic [WIDTH-1:0]   r_out;
  logic [WIDTH-1:0]   r_out_hi;
  logic               r_z, r_n, r_c, r_v, r_s, r_h;
  logic               r_err;
  logic               r_out_valid;
  logic [WIDTH-1:0]   r_mul_a;
  logic [2*WIDTH-1:0] r_prod;
  logic [SHW:0]       r_cnt;

  logic [WIDTH-1:0]   w_a;
  logic [WIDTH-1:0]   w_b;
  logic [SHW-1:0]     w_sh;
  logic               w_b_lt_w;
  logic               w_b_eq_w;
  logic               w_cin;
  logic [WIDTH:0]     w_add_full;
  logic [WIDTH:0]     w_sub_full;
  logic [4:0]         w_add_nib;
  logic [4:0]         w_sub_nib;
  logic [WIDTH:0]     w_sl_wide;
  logic [WIDTH:0]     w_sr_wide;
  logic [WIDTH:0]     w_asr_wide;
  logic [2*WIDTH-1:0] w_rot_wide;

  logic [WIDTH-1:0]   w_res;
  logic               w_c;
  logic               w_v;
  logic               w_h;
  logic               w_defined;

  logic [WIDTH:0]     w_mul_sum;
  logic [2*WIDTH-1:0] w_prod_next;
  logic               w_mul_hi_nz;

  assign w_a      = bus.a;
  assign w_b      = bus.b;
  assign w_sh     = w_b[SHW-1:0];
  assign w_b_lt_w = (w_b < WidthVal);
  assign w_b_eq_w = (w_b == WidthVal);

  // Shared arithmetic and shifter datapath. Shifts are one bit wider than the operand so
  // the last bit pushed out lands in the extra position and becomes the carry.
  always_comb begin
    w_cin = 1'b0;
    if (bus.op == OpAdc || bus.op == OpSbc) begin
      w_cin = r_c;
    end
    w_add_full = {1'b0, w_a} + {1'b0, w_b} + {{WIDTH{1'b0}}, w_cin};
    w_sub_full = {1'b0, w_a} - {1'b0, w_b} - {{WIDTH{1'b0}}, w_cin};
    w_add_nib  = {1'b0, w_a[3:0]} + {1'b0, w_b[3:0]} + {4'b0, w_cin};
    w_sub_nib  = {1'b0, w_a[3:0]} - {1'b0, w_b[3:0]} - {4'b0, w_cin};
    w_sl_wide  = {1'b0, w_a} << w_sh;
    w_sr_wide  = {w_a, 1'b0} >> w_sh;
    w_asr_wide = $signed({w_a, 1'b0}) >>> w_sh;
    w_rot_wide = {w_a, w_a} << w_sh;
  end

  // Result and carry/overflow/half-carry for all single-cycle ops.
  always_comb begin
    w_res     = '0;
    w_c       = 1'b0;
    w_v       = 1'b0;
    w_h       = 1'b0;
    w_defined = 1'b1;
    case (bus.op)
      OpLd:  w_res = w_a;
      OpAdd, OpAdc: begin
        w_res = w_add_full[WIDTH-1:0];
        w_c   = w_add_full[WIDTH];
        w_v   = (w_a[WIDTH-1] == w_b[WIDTH-1]) && (w_res[WIDTH-1] != w_a[WIDTH-1]);
        w_h   = w_add_nib[4];
      end
      OpSub, OpSbc, OpCmp: begin
        w_res = w_sub_full[WIDTH-1:0];
        w_c   = w_sub_full[WIDTH];
        w_v   = (w_a[WIDTH-1] != w_b[WIDTH-1]) && (w_res[WIDTH-1] != w_a[WIDTH-1]);
        w_h   = w_sub_nib[4];
      end
      OpAnd: w_res = w_a & w_b;
      OpOr:  w_res = w_a | w_b;
      OpXor: w_res = w_a ^ w_b;
      OpNot: w_res = ~w_a;
      OpSl: begin
        if (w_b_lt_w) begin
          w_res = w_sl_wide[WIDTH-1:0];
          w_c   = w_sl_wide[WIDTH];
        end else begin
          // Shifting by exactly WIDTH pushes a[0] out last; further shifts push zeros.
          w_c = w_b_eq_w & w_a[0];
        end
      end
      OpSr: begin
        if (w_b_lt_w) begin
          w_res = w_sr_wide[WIDTH:1];
          w_c   = w_sr_wide[0];
        end else begin
          w_c = w_b_eq_w & w_a[WIDTH-1];
        end
      end
      OpAsr: begin
        if (w_b_lt_w) begin
          w_res = w_asr_wide[WIDTH:1];
          w_c   = w_asr_wide[0];
        end else begin
          // Past the width, every bit shifted out is a copy of the sign.
          w_res = {WIDTH{w_a[WIDTH-1]}};
          w_c   = w_a[WIDTH-1];
        end
      end
      OpRol: begin
        w_res = w_rot_wide[2*WIDTH-1:WIDTH];
        // Bit rotated into the LSB is the last one shifted out of the MSB.
        w_c   = (w_sh != '0) & w_res[0];
      end
      OpMul: w_res = '0;
      default: w_defined = 1'b0;
    endcase
  end

  // One shift-add step: conditionally add the multiplicand into the high half, then
  // shift the whole product right; the multiplier bits drain out of the low end.
  always_comb begin
    w_mul_sum   = {1'b0, r_prod[2*WIDTH-1:WIDTH]} + (r_prod[0] ? {1'b0, r_mul_a} : '0);
    w_prod_next = {w_mul_sum, r_prod[WIDTH-1:1]};
    w_mul_hi_nz = |w_prod_next[2*WIDTH-1:WIDTH];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= StIdle;
      r_out       <= '0;
      r_out_hi    <= '0;
      r_z         <= 1'b0;
      r_n         <= 1'b0;
      r_c         <= 1'b0;
      r_v         <= 1'b0;
      r_s         <= 1'b0;
      r_h         <= 1'b0;
      r_err       <= 1'b0;
      r_out_valid <= 1'b0;
      r_mul_a     <= '0;
      r_prod      <= '0;
      r_cnt       <= '0;
    end else begin
      r_out_valid <= 1'b0;
      r_err       <= 1'b0;
      case (r_state)
        StIdle: begin
          if (bus.in_valid) begin
            if (bus.op == OpMul) begin
              r_mul_a <= w_a;
              r_prod  <= {{WIDTH{1'b0}}, w_b};
              r_cnt   <= '0;
              r_state <= StMul;
            end else if (w_defined) begin
              r_out_valid <= 1'b1;
              if (bus.op != OpCmp) begin
                r_out <= w_res;
              end
              r_out_hi <= '0;
              r_z      <= (w_res == '0);
              r_n      <= w_res[WIDTH-1];
              r_c      <= w_c;
              r_v      <= w_v;
              r_s      <= w_res[WIDTH-1] ^ w_v;
              r_h      <= w_h;
            end else begin
              // Undefined op: report it but leave every result register alone.
              r_out_valid <= 1'b1;
              r_err       <= 1'b1;
            end
          end
        end
        StMul: begin
          r_prod <= w_prod_next;
          r_cnt  <= r_cnt + 1'b1;
          if (r_cnt == LastIter) begin
            r_state     <= StIdle;
            r_out_valid <= 1'b1;
            r_out       <= w_prod_next[WIDTH-1:0];
            r_out_hi    <= w_prod_next[2*WIDTH-1:WIDTH];
            r_z         <= (w_prod_next == '0);
            r_n         <= w_prod_next[WIDTH-1];
            r_c         <= w_mul_hi_nz;
            r_v         <= w_mul_hi_nz;
            r_s         <= w_prod_next[WIDTH-1] ^ w_mul_hi_nz;
            r_h         <= 1'b0;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign bus.in_ready  = (r_state == StIdle);
  assign bus.out_valid = r_out_valid;
  assign bus.out       = r_out;
  assign bus.out_hi    = r_out_hi;
  assign bus.zflag     = r_z;
  assign bus.nflag     = r_n;
  assign bus.cflag     = r_c;
  assign bus.vflag     = r_v;
  assign bus.sflag     = r_s;
  assign bus.hflag     = r_h;
  assign bus.err       = r_err;

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed-vector bench for alu_seq at WIDTH=32. Flags are compared as the
// packed vector {z, n, c, v, s, h}.
module tb_alu_seq;
  localparam int unsigned W = 32;

  localparam logic [7:0] OpLd  = 8'h01;
  localparam logic [7:0] OpAdd = 8'h03;
  localparam logic [7:0] OpSub = 8'h04;
  localparam logic [7:0] OpAnd = 8'h05;
  localparam logic [7:0] OpOr  = 8'h06;
  localparam logic [7:0] OpXor = 8'h07;
  localparam logic [7:0] OpNot = 8'h08;
  localparam logic [7:0] OpSl  = 8'h09;
  localparam logic [7:0] OpSr  = 8'h0A;
  localparam logic [7:0] OpAdc = 8'h0B;
  localparam logic [7:0] OpSbc = 8'h0C;
  localparam logic [7:0] OpAsr = 8'h0D;
  localparam logic [7:0] OpRol = 8'h0E;
  localparam logic [7:0] OpMul = 8'h0F;
  localparam logic [7:0] OpCmp = 8'h10;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  alu_seq_if #(.WIDTH(W)) bus ();

  alu_seq #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [5:0] flags_now();
    return {bus.zflag, bus.nflag, bus.cflag, bus.vflag, bus.sflag, bus.hflag};
  endfunction

  // Present one request for one cycle; returns #1 after the accepting edge.
  task automatic issue(input logic [7:0] op_v, input logic [31:0] a_v, input logic [31:0] b_v);
    bus.in_valid = 1'b1;
    bus.op       = op_v;
    bus.a        = a_v;
    bus.b        = b_v;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic expect_res(input string tag, input logic [31:0] out_e, input logic [31:0] hi_e,
                            input logic [5:0] flg_e, input logic err_e);
    check({tag, ".valid"}, 64'(bus.out_valid), 64'd1);
    check({tag, ".out"},   64'(bus.out),       64'(out_e));
    check({tag, ".hi"},    64'(bus.out_hi),    64'(hi_e));
    check({tag, ".flags"}, 64'(flags_now()),   64'(flg_e));
    check({tag, ".err"},   64'(bus.err),       64'(err_e));
  endtask

  task automatic do_op(input string tag, input logic [7:0] op_v, input logic [31:0] a_v,
                       input logic [31:0] b_v, input logic [31:0] out_e, input logic [5:0] flg_e);
    issue(op_v, a_v, b_v);
    expect_res(tag, out_e, 32'h0, flg_e, 1'b0);
  endtask

  // Wait for out_valid after a MUL was accepted; counts edges and busy cycles.
  task automatic wait_mul(output int edges, output int busy);
    edges = 0;
    busy  = 0;
    while (!bus.out_valid && edges < 100) begin
      if (!bus.in_ready) busy++;
      @(posedge clk);
      #1;
      edges++;
      if (edges == 5) bus.in_valid = 1'b0;
    end
  endtask

  int edges;
  int busy;
  int pulses;

  initial begin
    rst          = 1'b1;
    bus.in_valid = 1'b0;
    bus.op       = 8'h00;
    bus.a        = '0;
    bus.b        = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    check("reset.valid", 64'(bus.out_valid), 64'd0);
    check("reset.out",   64'(bus.out),       64'd0);
    check("reset.hi",    64'(bus.out_hi),    64'd0);
    check("reset.flags", 64'(flags_now()),   64'd0);
    check("reset.err",   64'(bus.err),       64'd0);
    check("reset.ready", 64'(bus.in_ready),  64'd1);

    // Back-to-back single-cycle ops; flags {z,n,c,v,s,h}.
    do_op("add_wrap",  OpAdd, 32'hFFFF_FFFF, 32'h1, 32'h0000_0000, 6'b101001);
    do_op("adc_cin",   OpAdc, 32'h0, 32'h0, 32'h0000_0001, 6'b000000);
    do_op("add_ovf",   OpAdd, 32'h7FFF_FFFF, 32'h1, 32'h8000_0000, 6'b010101);
    do_op("sub_borrow", OpSub, 32'h3, 32'h5, 32'hFFFF_FFFE, 6'b011011);

    issue(8'h02, 32'h1234, 32'h5678);
    expect_res("undef", 32'hFFFF_FFFE, 32'h0, 6'b011011, 1'b1);

    do_op("cmp_eq",    OpCmp, 32'h5, 32'h5, 32'hFFFF_FFFE, 6'b100000);
    do_op("sub_c1",    OpSub, 32'h0, 32'h1, 32'hFFFF_FFFF, 6'b011011);
    do_op("sbc_cin",   OpSbc, 32'h10, 32'h3, 32'h0000_000C, 6'b000001);
    do_op("and",       OpAnd, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000, 6'b010010);
    do_op("or",        OpOr,  32'hF0F0_F0F0, 32'hFF00_FF00, 32'hFFF0_FFF0, 6'b010010);
    do_op("xor",       OpXor, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'h0FF0_0FF0, 6'b000000);
    do_op("not",       OpNot, 32'hF0F0_F0F0, 32'h0, 32'h0F0F_0F0F, 6'b000000);
    do_op("ld",        OpLd,  32'h1234_5678, 32'hDEAD_BEEF, 32'h1234_5678, 6'b000000);
    do_op("sl3",       OpSl,  32'h0000_FFFF, 32'd3, 32'h0007_FFF8, 6'b000000);
    do_op("sr3",       OpSr,  32'h0000_FFFF, 32'd3, 32'h0000_1FFF, 6'b001000);
    do_op("sl40",      OpSl,  32'h0000_FFFF, 32'd40, 32'h0000_0000, 6'b100000);
    do_op("asr4",      OpAsr, 32'h8000_0000, 32'd4, 32'hF800_0000, 6'b010010);
    do_op("asr100",    OpAsr, 32'h8000_0000, 32'd100, 32'hFFFF_FFFF, 6'b011010);
    do_op("rol4",      OpRol, 32'hF000_0000, 32'd4, 32'h0000_000F, 6'b001000);
    do_op("sl0",       OpSl,  32'h0000_0001, 32'd0, 32'h0000_0001, 6'b000000);
    do_op("sr32",      OpSr,  32'h8000_0000, 32'd32, 32'h0000_0000, 6'b101000);

    @(posedge clk);
    #1;
    check("idle.valid", 64'(bus.out_valid), 64'd0);

    // MUL with operands scrambled and a bogus request held while busy.
    issue(OpMul, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    bus.in_valid = 1'b1;
    bus.op       = OpAdd;
    bus.a        = 32'h0;
    bus.b        = 32'h0;
    wait_mul(edges, busy);
    // out_valid appears 32 edges after the accepting edge (33rd cycle overall).
    check("mul_max.latency", 64'(edges), 64'd32);
    check("mul_max.busy",    64'(busy),  64'd32);
    expect_res("mul_max", 32'h0000_0001, 32'hFFFF_FFFE, 6'b001110, 1'b0);
    check("mul_max.ready", 64'(bus.in_ready), 64'd1);

    do_op("add_after_mul", OpAdd, 32'h1, 32'h1, 32'h0000_0002, 6'b000000);

    issue(OpMul, 32'h3, 32'h5);
    wait_mul(edges, busy);
    check("mul_small.latency", 64'(edges), 64'd32);
    expect_res("mul_small", 32'h0000_000F, 32'h0, 6'b000000, 1'b0);

    // Reset 10 cycles into a multiply aborts it.
    issue(OpMul, 32'hFFFF_FFFF, 32'h2);
    repeat (9) begin
      @(posedge clk);
      #1;
    end
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("abort.valid", 64'(bus.out_valid), 64'd0);
    check("abort.out",   64'(bus.out),       64'd0);
    check("abort.hi",    64'(bus.out_hi),    64'd0);
    check("abort.flags", 64'(flags_now()),   64'd0);
    check("abort.err",   64'(bus.err),       64'd0);
    check("abort.ready", 64'(bus.in_ready),  64'd1);
    pulses = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (bus.out_valid) pulses++;
    end
    check("abort.no_result", 64'(pulses), 64'd0);

    // Reset wins over a simultaneous request.
    do_op("pre_rst", OpAdd, 32'h1, 32'h1, 32'h0000_0002, 6'b000000);
    bus.in_valid = 1'b1;
    bus.op       = OpAdd;
    bus.a        = 32'h5;
    bus.b        = 32'h5;
    rst          = 1'b1;
    @(posedge clk);
    #1;
    rst          = 1'b0;
    bus.in_valid = 1'b0;
    check("rst_req.valid", 64'(bus.out_valid), 64'd0);
    check("rst_req.out",   64'(bus.out),       64'd0);
    @(posedge clk);
    #1;
    check("rst_req.valid2", 64'(bus.out_valid), 64'd0);
    check("rst_req.out2",   64'(bus.out),       64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
